// File: rtl/goertzel_frame_seq_if.sv
// goertzel_frame_seq_if
// Bundles the control, status and datapath handshake signals of the
// Goertzel frame sequencer. Clock and reset stay outside the bundle.
//   slave  : the sequencer side. It receives commands and datapath
//            status, and drives enables and status.
//   master : the register-file / datapath side of the same signals.
// Signals:
//   start_i, cont_i, abort_i, num_samp_i : commands from the register block
//   coef_ok_i, smp_i, hrz_valid_i        : status from the datapath
//   en_coef_o, h_clr_o, smp_en_o         : datapath enables / clear
//   busy_o, done_o, samp_cnt_o,
//   frame_cnt_o, err_o, state_o          : status back to the register block
interface goertzel_frame_seq_if #(
  parameter int NF = 11,
  parameter int CW = 32
);
  logic          start_i;
  logic          cont_i;
  logic          abort_i;
  logic [CW-1:0] num_samp_i;
  logic          coef_ok_i;
  logic          smp_i;
  logic [NF-1:0] hrz_valid_i;
  logic          en_coef_o;
  logic          h_clr_o;
  logic          smp_en_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] samp_cnt_o;
  logic [15:0]   frame_cnt_o;
  logic [2:0]    err_o;
  logic [2:0]    state_o;

  modport slave (
    input  start_i, cont_i, abort_i, num_samp_i, coef_ok_i, smp_i, hrz_valid_i,
    output en_coef_o, h_clr_o, smp_en_o, busy_o, done_o, samp_cnt_o,
           frame_cnt_o, err_o, state_o
  );

  modport master (
    output start_i, cont_i, abort_i, num_samp_i, coef_ok_i, smp_i, hrz_valid_i,
    input  en_coef_o, h_clr_o, smp_en_o, busy_o, done_o, samp_cnt_o,
           frame_cnt_o, err_o, state_o
  );
endinterface

// File: rtl/goertzel_frame_seq.sv
// goertzel_frame_seq
// Frame sequencer for the Goertzel spectrum pipeline. A start command
// enables the coefficient chain and waits for it to settle. The
// sequencer then clears the Goertzel accumulators and gates exactly N
// samples into the scaler. It then waits until every bin reports a valid
// result and signals done. Continuous mode re-arms without regenerating
// the coefficients.
//
// Ports:
//   clk, rst : system clock and asynchronous active-high reset
//   bus      : goertzel_frame_seq_if.slave. It carries commands
//              (start/cont/abort/num_samp), datapath status
//              (coef_ok/smp/hrz_valid), enables (en_coef/h_clr/smp_en)
//              and status (busy/done/samp_cnt/frame_cnt/err/state).
//
// Optional feature: define GSEQ_TIMEOUT_EN to add a 16-bit watchdog.
// The watchdog aborts COEF or FLUSH after TO_CYC cycles and sets err[2].
module goertzel_frame_seq #(
  parameter int NF      = 11,
  parameter int CW      = 32,
  parameter int CLR_CYC = 2,
  parameter int TO_CYC  = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  goertzel_frame_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COEF  = 3'd1,
    CLR   = 3'd2,
    ACQ   = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] samp_cnt_q, samp_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [2:0]    err_q, err_d;
  logic [3:0]    clr_cnt_q, clr_cnt_d;
  logic          en_coef_q, h_clr_q, done_q, busy_q;
  logic          smp_en;
  logic          timeout;

`ifdef GSEQ_TIMEOUT_EN
  logic [15:0]   wd_q, wd_d;
  // The watchdog expires on the last allowed cycle in COEF or FLUSH.
  // The state therefore lasts exactly TO_CYC cycles before returning to IDLE.
  assign timeout = ((state_q == COEF) || (state_q == FLUSH)) &&
                   (wd_q == 16'(TO_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // A sample is accepted only while acquiring with valid coefficients.
  // Abort removes the enable in the same cycle, so no sample slips
  // through after the abort request.
  assign smp_en = (state_q == ACQ) & bus.smp_i & bus.coef_ok_i & ~bus.abort_i;

  // Next-state and next-counter logic. Abort takes precedence over
  // everything, then the watchdog, then the normal per-state flow.
  // Counters simply hold on abort.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    samp_cnt_d  = samp_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    clr_cnt_d   = clr_cnt_q;
    if (bus.abort_i) begin
      state_d = IDLE;
    end else if (timeout) begin
      state_d  = IDLE;
      err_d[2] = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.num_samp_i != '0) begin
              state_d    = COEF;
              n_d        = bus.num_samp_i;
              samp_cnt_d = '0;
              err_d      = '0;
            end else begin
              err_d[0] = 1'b1;
            end
          end
        end
        COEF: begin
          if (bus.coef_ok_i) begin
            state_d   = CLR;
            clr_cnt_d = '0;
          end
        end
        CLR: begin
          if (clr_cnt_q == 4'(CLR_CYC - 1)) begin
            state_d = ACQ;
          end else begin
            clr_cnt_d = clr_cnt_q + 4'd1;
          end
        end
        ACQ: begin
          if (!bus.coef_ok_i) begin
            state_d  = IDLE;
            err_d[1] = 1'b1;
          end else if (bus.smp_i) begin
            samp_cnt_d = samp_cnt_q + CW'(1);
            if (samp_cnt_d == n_q) begin
              state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          if (&bus.hrz_valid_i) begin
            state_d     = DONE;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
        DONE: begin
          if (bus.cont_i) begin
            state_d    = CLR;
            samp_cnt_d = '0;
            clr_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef GSEQ_TIMEOUT_EN
  // The watchdog restarts on every state change. It only advances while
  // waiting on the datapath, in COEF or FLUSH.
  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) && ((state_q == COEF) || (state_q == FLUSH))) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  // State, counters and registered outputs. The outputs are decoded from
  // the next state, so they line up with the state register without any
  // combinational path to the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      samp_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= '0;
      clr_cnt_q   <= '0;
      en_coef_q   <= 1'b0;
      h_clr_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      samp_cnt_q  <= samp_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      clr_cnt_q   <= clr_cnt_d;
      en_coef_q   <= (state_d != IDLE);
      h_clr_q     <= (state_d == CLR);
      done_q      <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.en_coef_o   = en_coef_q;
  assign bus.h_clr_o     = h_clr_q;
  assign bus.smp_en_o    = smp_en;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.samp_cnt_o  = samp_cnt_q;
  assign bus.frame_cnt_o = frame_cnt_q;
  assign bus.err_o       = err_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_goertzel_frame_seq.sv
// tb_goertzel_frame_seq
// Directed bench for goertzel_frame_seq. It drives the interface from one
// initial block. Pulse and cycle counts come from a negedge monitor.
// When GSEQ_TIMEOUT_EN is defined, the watchdog branch expects a timeout
// after 100 cycles.
module tb_goertzel_frame_seq;
  localparam int NF = 11;
  localparam int CW = 32;
  localparam logic [NF-1:0] ALLV = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   smpPulses  = 0;
  int   hclrCycles = 0;
  int   donePulses = 0;
  int   enDrops    = 0;
  logic watchEn    = 1'b0;

  goertzel_frame_seq_if #(.NF(NF), .CW(CW)) gif ();

  goertzel_frame_seq #(.NF(NF), .CW(CW), .CLR_CYC(2), .TO_CYC(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif.slave)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Counts enable pulses and clear/done cycles on the inactive edge.
  // Tests can then check totals over a whole frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (gif.smp_en_o)           smpPulses++;
      if (gif.h_clr_o)            hclrCycles++;
      if (gif.done_o)             donePulses++;
      if (watchEn && !gif.en_coef_o) enDrops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounts();
    smpPulses  = 0;
    hclrCycles = 0;
    donePulses = 0;
    enDrops    = 0;
  endtask

  task automatic applyStimulus(input logic start, input logic cont, input logic abort,
                               input logic [CW-1:0] n, input logic cok, input logic smp,
                               input logic [NF-1:0] hrz);
    gif.start_i     = start;
    gif.cont_i      = cont;
    gif.abort_i     = abort;
    gif.num_samp_i  = n;
    gif.coef_ok_i   = cok;
    gif.smp_i       = smp;
    gif.hrz_valid_i = hrz;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a state; an expired budget is reported as a failure.
  task automatic waitState(input logic [2:0] st, input int budget, input string tag);
    int k = 0;
    while (gif.state_o !== st && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(gif.state_o), 32'(st));
  endtask

  task automatic waitSamp(input logic [CW-1:0] n, input int budget, input string tag);
    int k = 0;
    while (gif.samp_cnt_o !== n && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(gif.samp_cnt_o), 32'(n));
  endtask

  initial begin
    int frames;
    applyStimulus(0, 0, 0, '0, 0, 0, '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    $display("[TB] reset state");
    checkOutput("rst_state", 32'(gif.state_o), 32'd0);
    checkOutput("rst_flags", 32'({gif.en_coef_o, gif.h_clr_o, gif.smp_en_o, gif.busy_o, gif.done_o}), 32'd0);
    checkOutput("rst_cnts", 32'(gif.samp_cnt_o) | 32'(gif.frame_cnt_o) | 32'(gif.err_o), 32'd0);

    // Single frame, N=8.
    $display("[TB] single frame N=8");
    clearCounts();
    applyStimulus(1, 0, 0, 8, 0, 1, '0);
    tick();
    applyStimulus(0, 0, 0, 8, 0, 1, '0);
    checkOutput("t1_coef_state", 32'(gif.state_o), 32'd1);
    checkOutput("t1_en_busy", 32'({gif.en_coef_o, gif.busy_o}), 32'b11);
    repeat (4) tick();
    gif.coef_ok_i = 1'b1;
    waitState(3'd3, 20, "t1_reach_acq");
    waitState(3'd4, 20, "t1_reach_flush");
    tick();
    tick();
    gif.hrz_valid_i = ALLV;
    tick();
    checkOutput("t1_done_state", 32'(gif.state_o), 32'd5);
    checkOutput("t1_done", 32'(gif.done_o), 32'd1);
    checkOutput("t1_frame_cnt", 32'(gif.frame_cnt_o), 32'd1);
    checkOutput("t1_samp_cnt", 32'(gif.samp_cnt_o), 32'd8);
    tick();
    checkOutput("t1_idle_after", 32'({gif.state_o, gif.busy_o, gif.en_coef_o, gif.done_o}), 32'd0);
    checkOutput("t1_smp_pulses", 32'(smpPulses), 32'd8);
    checkOutput("t1_hclr_cycles", 32'(hclrCycles), 32'd2);
    checkOutput("t1_done_pulses", 32'(donePulses), 32'd1);

    // Continuous mode, 3 frames of N=4, toggling sample strobe.
    $display("[TB] continuous mode N=4");
    rst = 1'b1;
    #2 rst = 1'b0;
    applyStimulus(1, 1, 0, 4, 1, 0, ALLV);
    tick();
    gif.start_i = 1'b0;
    clearCounts();
    watchEn = 1'b1;
    frames = 0;
    for (int c = 0; c < 300 && frames < 3; c++) begin
      gif.smp_i = ~gif.smp_i;
      tick();
      if (gif.done_o === 1'b1) begin
        frames++;
        if (frames == 3) gif.cont_i = 1'b0;
      end
    end
    watchEn = 1'b0;
    checkOutput("t2_frames_seen", 32'(frames), 32'd3);
    tick();
    checkOutput("t2_idle", 32'(gif.state_o), 32'd0);
    checkOutput("t2_frame_cnt", 32'(gif.frame_cnt_o), 32'd3);
    checkOutput("t2_smp_pulses", 32'(smpPulses), 32'd12);
    checkOutput("t2_hclr_cycles", 32'(hclrCycles), 32'd6);
    checkOutput("t2_en_drops", 32'(enDrops), 32'd0);

    // N=0 rejected.
    $display("[TB] zero-length start");
    applyStimulus(1, 0, 0, 0, 1, 0, '0);
    tick();
    gif.start_i = 1'b0;
    checkOutput("t3_state", 32'(gif.state_o), 32'd0);
    checkOutput("t3_err", 32'(gif.err_o), 32'b001);
    checkOutput("t3_en_coef", 32'(gif.en_coef_o), 32'd0);

    // Abort after 6 of 16 samples, then a full frame.
    $display("[TB] abort mid-acquisition");
    clearCounts();
    applyStimulus(1, 0, 0, 16, 1, 1, '0);
    tick();
    gif.start_i = 1'b0;
    checkOutput("t4_err_clear", 32'(gif.err_o), 32'd0);
    waitState(3'd3, 20, "t4_reach_acq");
    waitSamp(6, 30, "t4_samp6");
    gif.abort_i = 1'b1;
    #1;
    checkOutput("t4_smp_en_abort", 32'(gif.smp_en_o), 32'd0);
    tick();
    gif.abort_i = 1'b0;
    checkOutput("t4_state", 32'(gif.state_o), 32'd0);
    checkOutput("t4_smp_en", 32'(gif.smp_en_o), 32'd0);
    checkOutput("t4_samp_hold", 32'(gif.samp_cnt_o), 32'd6);
    checkOutput("t4_no_done", 32'(donePulses), 32'd0);
    checkOutput("t4_smp_pulses", 32'(smpPulses), 32'd6);
    clearCounts();
    applyStimulus(1, 0, 0, 16, 1, 1, ALLV);
    tick();
    gif.start_i = 1'b0;
    checkOutput("t4b_err", 32'(gif.err_o), 32'd0);
    waitState(3'd5, 60, "t4b_reach_done");
    checkOutput("t4b_samp", 32'(gif.samp_cnt_o), 32'd16);
    tick();
    checkOutput("t4b_smp_pulses", 32'(smpPulses), 32'd16);
    checkOutput("t4b_done_pulses", 32'(donePulses), 32'd1);

    // Coefficients lost after 3 of 10 samples.
    $display("[TB] coefficient loss");
    clearCounts();
    applyStimulus(1, 0, 0, 10, 1, 1, '0);
    tick();
    gif.start_i = 1'b0;
    waitState(3'd3, 20, "t5_reach_acq");
    waitSamp(3, 20, "t5_samp3");
    gif.coef_ok_i = 1'b0;
    #1;
    checkOutput("t5_smp_en_gate", 32'(gif.smp_en_o), 32'd0);
    tick();
    checkOutput("t5_state", 32'(gif.state_o), 32'd0);
    checkOutput("t5_err", 32'(gif.err_o), 32'b010);
    checkOutput("t5_samp", 32'(gif.samp_cnt_o), 32'd3);
    checkOutput("t5_no_done", 32'(donePulses), 32'd0);

    // Start and abort together: abort wins, error flags untouched.
    $display("[TB] start with abort");
    applyStimulus(1, 0, 1, 8, 1, 1, '0);
    tick();
    applyStimulus(0, 0, 0, 8, 1, 1, '0);
    checkOutput("t6_state", 32'(gif.state_o), 32'd0);
    checkOutput("t6_err_kept", 32'(gif.err_o), 32'b010);

    // N=1 boundary.
    $display("[TB] single-sample frame");
    clearCounts();
    applyStimulus(1, 0, 0, 1, 1, 1, '0);
    tick();
    gif.start_i = 1'b0;
    waitState(3'd4, 20, "t7_reach_flush");
    checkOutput("t7_samp", 32'(gif.samp_cnt_o), 32'd1);
    tick();
    checkOutput("t7_still_flush", 32'(gif.state_o), 32'd4);
    checkOutput("t7_smp_pulses", 32'(smpPulses), 32'd1);
    gif.abort_i = 1'b1;
    tick();
    gif.abort_i = 1'b0;
    checkOutput("t7_abort_idle", 32'(gif.state_o), 32'd0);

    // Coefficients never settle.
    $display("[TB] coefficient wait");
    applyStimulus(1, 0, 0, 8, 0, 0, '0);
    tick();
    gif.start_i = 1'b0;
    checkOutput("t8_coef", 32'(gif.state_o), 32'd1);
`ifdef GSEQ_TIMEOUT_EN
    repeat (99) tick();
    checkOutput("t8_before_to", 32'(gif.state_o), 32'd1);
    tick();
    checkOutput("t8_to_state", 32'(gif.state_o), 32'd0);
    checkOutput("t8_to_err", 32'(gif.err_o), 32'b100);
    checkOutput("t8_to_en", 32'(gif.en_coef_o), 32'd0);
`else
    repeat (150) tick();
    checkOutput("t8_wait_state", 32'(gif.state_o), 32'd1);
    checkOutput("t8_wait_err", 32'(gif.err_o), 32'd0);
    checkOutput("t8_wait_en", 32'(gif.en_coef_o), 32'd1);
    gif.abort_i = 1'b1;
    tick();
    gif.abort_i = 1'b0;
    checkOutput("t8_abort_idle", 32'(gif.state_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
